// File: rtl/adc_mem_reader.sv
// adc_mem_reader: read-back engine for the ADC capture RAM.
// A CSR start pulse streams NUM_SAMPLES consecutive words from ADDR_START
// onward out of a registered-read RAM and onto a valid/ready stream. A
// 2-entry first-word-fall-through buffer plus a one-deep in-flight credit
// keeps one word per cycle flowing and never drops a read under backpressure.
module adc_mem_reader #(
    parameter int                NUM_SAMPLES = 4096,
    parameter int                ADDR_W      = 13,
    parameter logic [ADDR_W-1:0] ADDR_START  = 13'h800,
    parameter int                DATA_W      = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              csr_start_i,
    output logic              csr_busy_o,
    output logic              csr_done_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);

    // Counters hold 0..NUM_SAMPLES inclusive so they can saturate at the run length.
    localparam int              CW     = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0]   NUM_C  = CW'(NUM_SAMPLES);
    localparam logic [CW-1:0]   LAST_C = CW'(NUM_SAMPLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [CW-1:0]          issued;
    logic [CW-1:0]          returned;
    logic [CW-1:0]          beat;
    logic                   inflight;

    logic [1:0][DATA_W-1:0] fifo_mem;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_count;

    logic [ADDR_W-1:0]      addr_hold;
    logic [ADDR_W-1:0]      addr_next;
    logic [2:0]             occupancy;
    logic                   running;
    logic                   start_go;
    logic                   push;
    logic                   pop;
    logic                   re;

    assign running  = (state == S_RUN);
    // A start while running is dropped so a run can never be restarted mid-flight.
    assign start_go = csr_start_i && !running;

    assign push = inflight;
    assign pop  = m_valid_o && m_ready_i;

    // Words buffered or already requested, after this cycle's pop frees a slot.
    // Issuing only while this is below 2 means every returning word has room.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign re        = running && (issued < NUM_C) && (occupancy < 3'd2);

    // Address arithmetic wraps naturally at the RAM width.
    assign addr_next  = ADDR_START + ADDR_W'(issued);
    assign mem_re_o   = re;
    assign mem_addr_o = re ? addr_next : addr_hold;

    assign m_valid_o  = (fifo_count != 2'd0);
    assign m_data_o   = fifo_mem[rd_ptr];
    assign m_last_o   = m_valid_o && (beat == LAST_C);

    assign csr_busy_o = running;
    assign csr_done_o = (state == S_DONE);

    // Run control: start from IDLE/DONE, finish when the last beat is taken.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else if (start_go) begin
            state <= S_RUN;
        end else if (running && pop && m_last_o) begin
            state <= S_DONE;
        end
    end

    // Issue/return/beat bookkeeping; inflight mirrors the RAM's one-cycle read latency.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            issued   <= '0;
            returned <= '0;
            beat     <= '0;
            inflight <= 1'b0;
        end else if (start_go) begin
            issued   <= '0;
            returned <= '0;
            beat     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= re;
            if (re) begin
                issued <= issued + 1'b1;
            end
            if (push && (returned < NUM_C)) begin
                returned <= returned + 1'b1;
            end
            if (pop && (beat < NUM_C)) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Keep the last issued address on the bus while no read is requested.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_hold <= '0;
        end else if (re) begin
            addr_hold <= addr_next;
        end
    end

    // Two-entry fall-through buffer; push and pop may coincide.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_mem   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else if (start_go) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: doc/adc_mem_reader.md
# adc_mem_reader

Read-back engine for the ADC capture buffer: on a CSR start pulse it reads `NUM_SAMPLES` consecutive 32-bit words from the capture RAM's read port, starting at `ADDR_START`. It presents them in order on a valid/ready stream toward the CPU/streaming side.

It is the read-side counterpart of `adc_mem_controller`, which fills the same RAM region. A 2-entry prefetch buffer sustains one word per cycle and absorbs backpressure, so no read is ever lost.

## Interface
Parameters:
- `NUM_SAMPLES`, 4096: words read per run (≥1).
- `ADDR_START`, 13'h800: first RAM address.
- `ADDR_W`, 13: RAM address width.
- `DATA_W`, 32: sample width.

Ports:
- `sys_clk`  in  1: single clock for the whole block.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `csr_start_i`  in  1: start request, sampled each rising edge.
- `csr_busy_o`  out  1: high in RUNNING.
- `csr_done_o`  out  1: high in DONE.
- `mem_re_o`  out  1: RAM read enable.
- `mem_addr_o`  out  ADDR_W: RAM read address.
- `mem_data_i`  in  DATA_W: RAM read data, valid the cycle after `mem_re_o` (registered RAM).
- `m_valid_o`  out  1: stream data valid.
- `m_data_o`  out  DATA_W: stream data.
- `m_last_o`  out  1: marks word `NUM_SAMPLES-1`.
- `m_ready_i`  in  1: stream consumer ready.

## Operation
- **States:** IDLE, RUNNING, DONE.
  - IDLE/DONE + `csr_start_i`=1 → RUNNING. This clears the issue counter, return counter, beat counter, in-flight flag and FIFO.
  - RUNNING + last beat accepted (`m_valid_o & m_ready_i & m_last_o`) → DONE.
  - DONE holds until the next start.
- **Start in RUNNING:** `csr_start_i` is ignored.
- **Read issue:**
  - `mem_re_o` is combinational: asserted in RUNNING when `issued < NUM_SAMPLES` and `fifo_count + inflight - pop < 2`.
  - `pop` = `m_valid_o & m_ready_i` in the same cycle.
  - `mem_addr_o` = `ADDR_START + issued`, truncated to `ADDR_W` (wraps modulo 2^ADDR_W). When `mem_re_o`=0, `mem_addr_o` holds its last value.
- **Return:** `inflight` is a registered copy of `mem_re_o`. When `inflight`=1, `mem_data_i` is written into the FIFO at that clock edge.
- **FIFO:**
  - Depth 2, first-word fall-through: `m_valid_o` = FIFO not empty, `m_data_o` = head.
  - Push and pop may occur in the same cycle.
  - The credit rule guarantees the FIFO never overflows.
- **`m_last_o`:** asserted with the head word when the beat counter equals `NUM_SAMPLES-1`. Only meaningful while `m_valid_o`=1; driven 0 otherwise.
- **Stream hold:** while `m_valid_o`=1 and `m_ready_i`=0, `m_data_o`/`m_last_o` stay stable.
- **Counter widths:** `issued`, `returned` and `beat` are `$clog2(NUM_SAMPLES+1)` bits and saturate at `NUM_SAMPLES`.

## Timing
- **Reset values:** all outputs 0, state IDLE, FIFO empty, all counters 0. Reset mid-run aborts immediately; the next run after reset starts from `ADDR_START`.
- **Start latency:**
  - Start sampled at edge T0 → RUNNING in cycle 1.
  - Cycle 1: `csr_busy_o`=1, `mem_re_o`=1, `mem_addr_o`=`ADDR_START`.
  - Cycle 2: `mem_data_i` valid.
  - Cycle 3: first `m_valid_o`=1.
- **Throughput:** with `m_ready_i` held high, one beat per cycle. A full run finishes with the last beat in cycle `NUM_SAMPLES+2`.
- **Done timing:** `csr_done_o` rises, and `csr_busy_o` falls, in the cycle after the last beat handshake.
- **Stalls:** with `m_ready_i`=0 from the start, exactly 2 reads are issued, then `mem_re_o` stays 0 until a pop.
- **`NUM_SAMPLES`=1:** one read; `m_last_o`=1 on the only beat.
- **Start and done in the same cycle:** impossible, because start is only honoured outside RUNNING.

## Test plan
- **Basic readback:** RAM model returns data = address. Pulse start with `m_ready_i`=1 → 4096 beats, data 0x800…0x17FF in order. `m_last_o` only on data 0x17FF; `csr_done_o`=1 one cycle later. First `m_valid_o` exactly 3 cycles after the start edge.
- **Random backpressure:** `m_ready_i` random 50% →
  - Same 4096-word sequence, with no drop or duplicate.
  - `fifo_count + inflight` never exceeds 2.
  - `m_data_o` stable during every stall.
- **Full stall:** `m_ready_i`=0 for 20 cycles after start → exactly 2 `mem_re_o` pulses (addresses 0x800, 0x801). Releasing `m_ready_i` resumes at 0x802.
- **Ignored start:** pulse start at beat 100 while RUNNING → no restart; the sequence and the 4096 total are unchanged.
- **Reset and restart:**
  - Assert `sys_rst_n`=0 mid-run at beat 1000 → all outputs 0 immediately. After release and a new start, the run begins again at 0x800.
  - A start issued from DONE also reruns all 4096 words.
- **Address wrap:** `ADDR_START`=13'h1FFE, `NUM_SAMPLES`=4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
